// File: rtl/if_id_ibuf_if.sv
// Fetch-to-decode bundle for the instruction buffer: fetch push side (no ready)
// plus the valid/ready decode side. "slave" is the buffer's view.
interface if_id_ibuf_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              in_valid_i;
  logic [DATA_W-1:0] in_inst_i;
  logic [ADDR_W-1:0] in_addr_i;
  logic              in_pred_branch_i;
  logic              in_err_i;

  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_inst_o;
  logic [ADDR_W-1:0] out_addr_o;
  logic              out_pred_branch_o;
  logic              out_err_o;

  modport slave (
    input  in_valid_i, in_inst_i, in_addr_i, in_pred_branch_i, in_err_i,
    input  out_ready_i,
    output out_valid_o, out_inst_o, out_addr_o, out_pred_branch_o, out_err_o
  );

  modport master (
    output in_valid_i, in_inst_i, in_addr_i, in_pred_branch_i, in_err_i,
    output out_ready_i,
    input  out_valid_o, out_inst_o, out_addr_o, out_pred_branch_o, out_err_o
  );
endinterface

// File: rtl/if_id_ibuf.sv
// Circular instruction buffer between fetch and decode; 1-cycle push-to-head latency.
// Fetch has no ready: stall_req_o is raised SKID entries early, overflow drops are sticky.
module if_id_ibuf #(
  parameter int DEPTH  = 4,
  parameter int SKID   = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  if_id_ibuf_if.slave              bus,
  output logic                     stall_req_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] FULL_CNT  = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] STALL_CNT = PTR_W'(DEPTH - SKID);

  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] addr;
    logic              pred_branch;
    logic              err;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count, count_d;
  logic             stall_q, stall_d;
  logic             ovf_q, ovf_d;
  logic             empty, full, push, pop, drop, wr_en;
  entry_t           wr_entry, head;

  assign wr_entry = '{inst:        bus.in_inst_i,
                      addr:        bus.in_addr_i,
                      pred_branch: bus.in_pred_branch_i,
                      err:         bus.in_err_i};

  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    empty    = (count == '0);
    full     = (count == FULL_CNT);
    pop      = !empty && bus.out_ready_i;
    // A full buffer still takes a new entry when the head leaves in the same cycle.
    push     = bus.in_valid_i && (!full || pop);
    drop     = bus.in_valid_i && full && !pop && !flush_i;
    wr_en    = push && !flush_i;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    count_d  = count;
    stall_d  = stall_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      count_d  = '0;
      stall_d  = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop};
      ovf_d    = ovf_q | drop;
      count_d  = wr_ptr_d - rd_ptr_d;
      stall_d  = (count_d >= STALL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      stall_q  <= stall_d;
      ovf_q    <= ovf_d;
      if (wr_en) begin
        mem_q[wr_ptr_q[IDX_W-1:0]] <= wr_entry;
      end
    end
  end

  assign head                  = mem_q[rd_ptr_q[IDX_W-1:0]];
  assign bus.out_valid_o       = !empty;
  assign bus.out_inst_o        = head.inst;
  assign bus.out_addr_o        = head.addr;
  assign bus.out_pred_branch_o = head.pred_branch;
  assign bus.out_err_o         = head.err;
  assign stall_req_o           = stall_q;
  assign overflow_o            = ovf_q;
  assign count_o               = count;

endmodule
